motor_scheduler: RTL

MOTOR_SCHEDULER -- requirements
Module: motor_scheduler

---
 rtl/motor_pkg.sv | 26 ++
 rtl/cmd_fifo.sv | 63 ++++++
 rtl/motor_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: shared definitions for the motor scheduler slice.
//   N_MOTOR      - number of motors driven by the scheduler
//   POS_W        - width of a position / target value (0-999)
//   MIDX_W       - width of a motor index (0-5)
//   state_t      - scheduler FSM states
//   fifo_entry_t - one queued move command (motor index + absolute target)
package motor_pkg;

    localparam int N_MOTOR = 6;
    localparam int POS_W   = 10;
    localparam int MIDX_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP_HI,
        STEP_LO,
        FINISH
    } state_t;

    typedef struct packed {
        logic [MIDX_W-1:0] motor;
        logic [POS_W-1:0]  target;
    } fifo_entry_t;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: small synchronous FIFO of move commands.
//   sysclk  - clock, rising edge
//   INIT_n  - asynchronous active-low reset (empties the FIFO)
//   push    - write wr_data (ignored while full)
//   wr_data - entry to write
//   pop     - discard the head entry (ignored while empty)
//   rd_data - current head entry
//   full    - FIFO holds FIFO_DEPTH entries
//   empty   - FIFO holds no entries
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo
    import motor_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sysclk,
    input  logic        INIT_n,
    input  logic        push,
    input  fifo_entry_t wr_data,
    input  logic        pop,
    output fifo_entry_t rd_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    fifo_entry_t   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Fullness is taken from the registered count, so a push while full is
    // refused even when a pop happens in the same cycle.
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge sysclk or negedge INIT_n) begin
        if (!INIT_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/motor_scheduler.sv
// motor_scheduler: queues BCD move commands and steps one motor at a time.
//   sysclk              - clock, rising edge
//   INIT_n              - asynchronous active-low reset
//   Cmd_Valid           - single-cycle command strobe
//   Cmd_Motor           - one-hot motor select, bit0 = motor 1
//   Cmd_V0/Cmd_V1/Cmd_V2- BCD hundreds/tens/ones of absolute target
//   Cmd_Ready           - command FIFO not full
//   Cmd_Drop            - one-cycle pulse after a rejected strobe
//   Step/Dir            - per-motor step pulse and direction (1 = up)
//   Busy                - move in LOAD/STEP_HI/STEP_LO
//   Done                - one-cycle pulse at the end of each move
//   Cur_Motor           - index of the active or last motor
module motor_scheduler
    import motor_pkg::*;
#(
    parameter int STEP_DIV   = 50000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       INIT_n,
    input  logic       Cmd_Valid,
    input  logic [5:0] Cmd_Motor,
    input  logic [3:0] Cmd_V0,
    input  logic [3:0] Cmd_V1,
    input  logic [3:0] Cmd_V2,
    output logic       Cmd_Ready,
    output logic       Cmd_Drop,
    output logic [5:0] Step,
    output logic [5:0] Dir,
    output logic       Busy,
    output logic       Done,
    output logic [2:0] Cur_Motor
);

    localparam int HALF = STEP_DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [POS_W-1:0]  tgt;
    logic [POS_W-1:0]  pos [N_MOTOR];
    logic [POS_W-1:0]  step_pos;
    logic              half_done;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              accept;
    logic              cmd_ok;
    logic [MIDX_W-1:0] motor_idx;
    fifo_entry_t       wr_entry;
    fifo_entry_t       head;

    always_comb begin
        motor_idx = '0;
        for (int unsigned i = 0; i < N_MOTOR; i++) begin
            if (Cmd_Motor[i]) motor_idx = MIDX_W'(i);
        end
    end

    assign cmd_ok = $onehot(Cmd_Motor) &&
                    (Cmd_V0 <= 4'd9) && (Cmd_V1 <= 4'd9) && (Cmd_V2 <= 4'd9);
    assign accept = Cmd_Valid && cmd_ok && !fifo_full;

    assign wr_entry.motor  = motor_idx;
    assign wr_entry.target = POS_W'(Cmd_V0) * POS_W'(100) +
                             POS_W'(Cmd_V1) * POS_W'(10) +
                             POS_W'(Cmd_V2);

    assign Cmd_Ready = !fifo_full;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign half_done = (cnt == CW'(HALF - 1));
    assign step_pos  = Dir[Cur_Motor] ? pos[Cur_Motor] + 1'b1
                                      : pos[Cur_Motor] - 1'b1;

    cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk  (sysclk),
        .INIT_n  (INIT_n),
        .push    (accept),
        .wr_data (wr_entry),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The head entry is captured on the IDLE->LOAD edge, the same edge that
    // pops it; LOAD then works from the latched motor and target.
    always_ff @(posedge sysclk or negedge INIT_n) begin
        if (!INIT_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tgt       <= '0;
            Step      <= '0;
            Dir       <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Cmd_Drop  <= 1'b0;
            Cur_Motor <= '0;
            for (int unsigned i = 0; i < N_MOTOR; i++) pos[i] <= '0;
        end else begin
            Cmd_Drop <= Cmd_Valid && !accept;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        Cur_Motor <= head.motor;
                        tgt       <= head.target;
                        Busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    Dir[Cur_Motor] <= (tgt > pos[Cur_Motor]);
                    cnt            <= '0;
                    if (tgt == pos[Cur_Motor]) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        Step[Cur_Motor] <= 1'b1;
                        state           <= STEP_HI;
                    end
                end
                STEP_HI: begin
                    if (half_done) begin
                        cnt   <= '0;
                        Step  <= '0;
                        state <= STEP_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STEP_LO: begin
                    if (half_done) begin
                        cnt            <= '0;
                        pos[Cur_Motor] <= step_pos;
                        if (step_pos == tgt) begin
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            Step[Cur_Motor] <= 1'b1;
                            state           <= STEP_HI;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FINISH: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
